// File: rtl/cpu_pkg.sv
// Shared CPU definitions: default PC vectors, next-PC source encoding and
// the branch-target helper used by the fetch-stage next-PC logic.
package cpu_pkg;

    localparam logic [31:0] RESET_PC_DEF   = 32'h0000_3000;
    localparam logic [31:0] EXC_VECTOR_DEF = 32'h0000_4180;

    // Source of the next fetch address.
    typedef enum logic [2:0] {
        NPC_SEQ,
        NPC_BR,
        NPC_J,
        NPC_JR,
        NPC_PEND
    } npc_sel_t;

    // id_pc4 + sign_extend(offset) * 4, wrapping modulo 2^32.
    function automatic logic [31:0] branch_target(input logic [31:0] pc4,
                                                  input logic [15:0] offset);
        return pc4 + {{14{offset[15]}}, offset, 2'b00};
    endfunction

    // Region-relative jump: upper nibble of the ID pc+4 and the 26-bit word index.
    function automatic logic [31:0] jump_target(input logic [31:0] pc4,
                                                input logic [25:0] index);
        return {pc4[31:28], index, 2'b00};
    endfunction

endpackage

// File: rtl/pc_reg_npc_mux.sv
// npc_mux: combinational next-PC selector. Computes the branch and jump
// targets and picks the winner: jr > jump > branch > pending redirect > pc+4.
module npc_mux
    import cpu_pkg::*;
(
    input  logic [31:0] pc4_if,
    input  logic [31:0] id_pc4,
    input  logic        br_taken,
    input  logic [15:0] br_offset,
    input  logic        jump,
    input  logic [25:0] instr_index,
    input  logic        jr,
    input  logic [31:0] jr_addr,
    input  logic        redirect_pending,
    input  logic [31:0] pend_addr,
    output npc_sel_t    sel,
    output logic [31:0] npc
);

    // Priority select of the next fetch address.
    always_comb begin
        // NOTE: defaults first so every path assigns sel/npc and no latch is inferred.
        sel = NPC_SEQ;
        npc = pc4_if;
        if (jr) begin
            sel = NPC_JR;
            npc = jr_addr;
        end else if (jump) begin
            sel = NPC_J;
            npc = jump_target(id_pc4, instr_index);
        end else if (br_taken) begin
            sel = NPC_BR;
            npc = branch_target(id_pc4, br_offset);
        end else if (redirect_pending) begin
            sel = NPC_PEND;
            npc = pend_addr;
        end
    end

endmodule

// File: rtl/pc_reg.sv
// pc_reg: fetch program counter with a one-entry pending-redirect buffer that
// holds a redirect raised while the pipeline is stalled.
// Optional macro PC_ALIGN_CHECK_EN: a misaligned next PC is replaced by
// EXC_VECTOR and adel pulses for one cycle; otherwise adel is tied low.
module pc_reg
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
    parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF
)(
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [31:0] pc4_if,
    input  logic [31:0] id_pc4,
    input  logic        br_taken,
    input  logic [15:0] br_offset,
    input  logic        jump,
    input  logic [25:0] instr_index,
    input  logic        jr,
    input  logic [31:0] jr_addr,
    output logic [31:0] pc,
    output logic        redirect_pending,
    output logic        adel
);

    npc_sel_t    sel;
    logic [31:0] npc;
    logic [31:0] pend_addr;
    logic        live_valid;

    // Both vectors are fetch addresses and must be word-aligned.
    if ((RESET_PC[1:0] != 2'b00) || (EXC_VECTOR[1:0] != 2'b00)) begin : g_bad_vector
        $error("pc_reg: RESET_PC and EXC_VECTOR must be word-aligned");
    end

    npc_mux u_npc_mux (
        .pc4_if           (pc4_if),
        .id_pc4           (id_pc4),
        .br_taken         (br_taken),
        .br_offset        (br_offset),
        .jump             (jump),
        .instr_index      (instr_index),
        .jr               (jr),
        .jr_addr          (jr_addr),
        .redirect_pending (redirect_pending),
        .pend_addr        (pend_addr),
        .sel              (sel),
        .npc              (npc)
    );

    // A redirect requested by the ID instruction this cycle (not the buffered one).
    assign live_valid = (sel == NPC_JR) || (sel == NPC_J) || (sel == NPC_BR);

    // PC update when running; capture the newest live redirect when stalled.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: non-blocking assignments for all state so every register samples pre-edge values.
        if (reset) begin
            pc               <= RESET_PC;
            redirect_pending <= 1'b0;
            pend_addr        <= 32'h0;
`ifdef PC_ALIGN_CHECK_EN
            adel             <= 1'b0;
`endif
        end else if (!stall) begin
            // A live redirect outranks the buffered one, which is dropped either way.
            redirect_pending <= 1'b0;
`ifdef PC_ALIGN_CHECK_EN
            if (npc[1:0] != 2'b00) begin
                pc   <= EXC_VECTOR;
                adel <= 1'b1;
            end else begin
                pc   <= npc;
                adel <= 1'b0;
            end
`else
            pc <= npc;
`endif
        end else begin
`ifdef PC_ALIGN_CHECK_EN
            adel <= 1'b0;
`endif
            if (live_valid) begin
                pend_addr        <= npc;
                redirect_pending <= 1'b1;
            end
        end
    end

`ifndef PC_ALIGN_CHECK_EN
    assign adel = 1'b0;
`endif

endmodule

// File: tb/tb_pc_reg.sv
// tb_pc_reg: directed scenarios with literal expectations plus a randomized
// run, all compared every cycle against a behavioural model of the PC rules.
module tb_pc_reg;

    localparam logic [31:0] RST_PC  = 32'h0000_3000;
    localparam logic [31:0] EXC_VEC = 32'h0000_4180;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic [31:0] pc4_if;
    logic [31:0] id_pc4;
    logic        br_taken;
    logic [15:0] br_offset;
    logic        jump;
    logic [25:0] instr_index;
    logic        jr;
    logic [31:0] jr_addr;
    logic [31:0] pc;
    logic        redirect_pending;
    logic        adel;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // The IF incrementer.
    assign pc4_if = pc + 32'd4;

    pc_reg dut (
        .clk              (clk),
        .reset            (reset),
        .stall            (stall),
        .pc4_if           (pc4_if),
        .id_pc4           (id_pc4),
        .br_taken         (br_taken),
        .br_offset        (br_offset),
        .jump             (jump),
        .instr_index      (instr_index),
        .jr               (jr),
        .jr_addr          (jr_addr),
        .pc               (pc),
        .redirect_pending (redirect_pending),
        .adel             (adel)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_pc;
    logic        m_pend;
    logic [31:0] m_paddr;
    logic        m_adel;

    // {valid, address} of the ID-stage redirect request, highest priority first.
    function automatic logic [32:0] live_req();
        if (jr)       return {1'b1, jr_addr};
        if (jump)     return {1'b1, (id_pc4 & 32'hF000_0000) | (32'(instr_index) * 32'd4)};
        if (br_taken) return {1'b1, id_pc4 + 32'($signed(br_offset)) * 32'd4};
        return 33'd0;
    endfunction

    logic [32:0] m_live;
    logic [31:0] m_next;
    always_comb begin
        m_live = live_req();
        m_next = m_live[32] ? m_live[31:0] : (m_pend ? m_paddr : pc4_if);
    end

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_pc    <= RST_PC;
            m_pend  <= 1'b0;
            m_paddr <= 32'h0;
            m_adel  <= 1'b0;
        end else if (!stall) begin
            m_pend <= 1'b0;
`ifdef PC_ALIGN_CHECK_EN
            m_pc   <= (m_next % 4 != 0) ? EXC_VEC : m_next;
            m_adel <= (m_next % 4 != 0);
`else
            m_pc   <= m_next;
            m_adel <= 1'b0;
`endif
        end else begin
            m_adel <= 1'b0;
            if (m_live[32]) begin
                m_pend  <= 1'b1;
                m_paddr <= m_live[31:0];
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (!reset) begin
            check("pc_model", pc, m_pc);
            check("pending_model", {31'd0, redirect_pending}, {31'd0, m_pend});
            check("adel_model", {31'd0, adel}, {31'd0, m_adel});
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle_inputs();
        stall       = 1'b0;
        br_taken    = 1'b0;
        br_offset   = 16'h0;
        jump        = 1'b0;
        instr_index = 26'h0;
        jr          = 1'b0;
        jr_addr     = 32'h0;
        id_pc4      = 32'h0;
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();

        // 1. reset and sequential fetch
        repeat (3) @(posedge clk);
        #1;
        check("reset_pc", pc, RST_PC);
        check("reset_pending", {31'd0, redirect_pending}, 32'd0);
        check("reset_adel", {31'd0, adel}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        after_edge();
        check("seq_1", pc, 32'h0000_3004);
        after_edge();
        check("seq_2", pc, 32'h0000_3008);
        #2 reset = 1'b1;
        #1 check("async_reset_pc", pc, RST_PC);
        @(negedge clk);
        reset = 1'b0;

        // 2. taken branches, backward and forward
        id_pc4 = 32'h0000_3010; br_taken = 1'b1; br_offset = 16'hFFFC;
        after_edge();
        check("br_back", pc, 32'h0000_3000);
        @(negedge clk);
        br_offset = 16'h0004;
        after_edge();
        check("br_fwd", pc, 32'h0000_3020);

        // 3. priority jr > jump > branch
        @(negedge clk);
        jr = 1'b1; jump = 1'b1; br_taken = 1'b1; jr_addr = 32'h0000_3400;
        id_pc4 = 32'h0000_3004; instr_index = 26'h0000D40; br_offset = 16'h0100;
        after_edge();
        check("prio_jr", pc, 32'h0000_3400);
        @(negedge clk);
        jr = 1'b0; instr_index = 26'h0000D00;
        after_edge();
        check("prio_jump", pc, 32'h0000_3400);

        // 4. jump absorbed during a 3-cycle stall
        @(negedge clk);
        idle_inputs();
        after_edge();
        check("pre_stall_seq", pc, 32'h0000_3404);
        @(negedge clk);
        stall = 1'b1; jump = 1'b1; id_pc4 = 32'h0000_3004; instr_index = 26'h0000D00;
        after_edge();
        check("stall_c1_pc", pc, 32'h0000_3404);
        check("stall_c1_pend", {31'd0, redirect_pending}, 32'd1);
        @(negedge clk);
        jump = 1'b0;
        after_edge();
        check("stall_c2_pend", {31'd0, redirect_pending}, 32'd1);
        after_edge();
        check("stall_c3_pc", pc, 32'h0000_3404);
        check("stall_c3_pend", {31'd0, redirect_pending}, 32'd1);
        @(negedge clk);
        stall = 1'b0;
        after_edge();
        check("pend_applied", pc, 32'h0000_3400);
        check("pend_cleared", {31'd0, redirect_pending}, 32'd0);

        // 5. live branch beats the pending jump on stall release
        @(negedge clk);
        stall = 1'b1; jump = 1'b1;
        after_edge();
        check("pend_set", {31'd0, redirect_pending}, 32'd1);
        @(negedge clk);
        stall = 1'b0; jump = 1'b0; br_taken = 1'b1;
        id_pc4 = 32'h0000_3000; br_offset = 16'h0040;
        after_edge();
        check("live_wins_pc", pc, 32'h0000_3100);
        check("live_wins_pend", {31'd0, redirect_pending}, 32'd0);

        // Reset while a redirect is pending
        @(negedge clk);
        idle_inputs();
        stall = 1'b1; jump = 1'b1; id_pc4 = 32'h0000_3004; instr_index = 26'h0000D00;
        after_edge();
        #1 reset = 1'b1;
        #1;
        check("rst_pend_pc", pc, RST_PC);
        check("rst_pend_flag", {31'd0, redirect_pending}, 32'd0);
        @(negedge clk);
        reset = 1'b0; idle_inputs();
        after_edge();
        check("rst_pend_lost", pc, 32'h0000_3004);

        // 6. misaligned jr target
        @(negedge clk);
        jr = 1'b1; jr_addr = 32'h0000_3402;
        after_edge();
`ifdef PC_ALIGN_CHECK_EN
        check("misalign_pc", pc, EXC_VEC);
        check("misalign_adel", {31'd0, adel}, 32'd1);
`else
        check("misalign_pc", pc, 32'h0000_3402);
        check("misalign_adel", {31'd0, adel}, 32'd0);
`endif
        @(negedge clk);
        jr = 1'b0;
        after_edge();
        check("adel_one_cycle", {31'd0, adel}, 32'd0);

        // Randomized run checked by the model process.
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            reset       = ($urandom_range(0, 149) == 0);
            stall       = ($urandom_range(0, 99) < 35);
            jr          = ($urandom_range(0, 99) < 10);
            jump        = ($urandom_range(0, 99) < 12);
            br_taken    = ($urandom_range(0, 99) < 15);
            br_offset   = 16'($urandom);
            instr_index = 26'($urandom);
            id_pc4      = $urandom & 32'hFFFF_FFFC;
            jr_addr     = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
        end
        @(negedge clk);
        reset = 1'b0;
        idle_inputs();
        repeat (3) @(posedge clk);
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
